// File: rtl/op_pkg.sv
// Shared types for the push-button opcode front end: opcode encoding,
// controller states and the default operand width.
package op_pkg;

  localparam int OPW = 8;

  typedef enum logic [1:0] {OP_00, OP_01, OP_10, OP_11} opcode_t;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, ISSUE, WAIT_RELEASE} state_t;

endpackage

// File: rtl/op_select_encoder_if.sv
// Button/operand inputs and command outputs of op_select_encoder, bundled
// so board glue and the decoder side see one connection point.
interface op_select_encoder_if
  import op_pkg::*;
#(
  parameter int W = OPW
) ();

  logic [3:0]          btn;
  logic signed [W-1:0] a_in;
  logic signed [W-1:0] b_in;
  logic                s_1;
  logic                s_0;
  logic signed [W-1:0] a_out;
  logic signed [W-1:0] b_out;
  logic                op_valid;
  logic                busy;

  modport master (
    output btn, a_in, b_in,
    input  s_1, s_0, a_out, b_out, op_valid, busy
  );

  modport slave (
    input  btn, a_in, b_in,
    output s_1, s_0, a_out, b_out, op_valid, busy
  );

endinterface

// File: rtl/btn_sync.sv
// Two-flop synchroniser for the four asynchronous push-buttons.
module btn_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  output logic [3:0] sbtn
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= btn;
      sync_q <= meta_q;
    end
  end

  assign sbtn = sync_q;

endmodule

// File: rtl/op_select_encoder.sv
// Debounced, priority-encoded button front end: one registered opcode plus
// latched operands and a single op_valid pulse per accepted press.
module op_select_encoder
  import op_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int W               = OPW
) (
  input logic               clk,
  input logic               reset,
  op_select_encoder_if.slave bus
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]          sbtn;
  logic                any;
  opcode_t             code;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
  opcode_t             cand_q, cand_d;
  opcode_t             op_q, op_d;
  logic signed [W-1:0] a_q, a_d;
  logic signed [W-1:0] b_q, b_d;

  btn_sync u_btn_sync (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.btn),
    .sbtn  (sbtn)
  );

  always_comb begin
    code = OP_00;
    if (sbtn[3])      code = OP_11;
    else if (sbtn[2]) code = OP_10;
    else if (sbtn[1]) code = OP_01;
  end

  assign any = |sbtn;

  // Saturating increment; the FSM leaves each counting state at CNT_LAST.
  assign cnt_inc = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (any) begin
          cand_d  = code;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!any || code != cand_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ISSUE;
          op_d    = cand_q;
          a_d     = bus.a_in;
          b_d     = bus.b_in;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ISSUE: begin
        state_d = WAIT_RELEASE;
        cnt_d   = '0;
      end
      WAIT_RELEASE: begin
        if (any)                    cnt_d   = '0;
        else if (cnt_q == CNT_LAST) state_d = IDLE;
        else                        cnt_d   = cnt_inc;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= OP_00;
      op_q    <= OP_00;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign {bus.s_1, bus.s_0} = op_q;
  assign bus.a_out          = a_q;
  assign bus.b_out          = b_q;
  assign bus.op_valid       = (state_q == ISSUE);
  assign bus.busy           = (state_q != IDLE);

endmodule

// File: tb/tb_op_select_encoder.sv
// Self-checking bench for op_select_encoder: directed scenarios plus random
// button/operand traffic against a run-length reference model.
module tb_op_select_encoder;

  localparam int DB = 4;
  localparam int W  = 8;

  typedef logic [2*W+3:0] vec_t;

  logic clk = 1'b0;
  logic reset;

  op_select_encoder_if #(.W(W)) bus ();

  op_select_encoder #(.DEBOUNCE_CYCLES(DB), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: btn delayed two edges, then a press is accepted after
  // DB+1 consecutive edges showing the same winning button, and the next
  // press is only considered after DB consecutive all-released edges.
  logic [3:0]          m_s1, m_s2;
  int                  m_run, m_rel, m_cand;
  bit                  m_pulse, m_releasing;
  logic [1:0]          e_s;
  logic signed [W-1:0] e_a, e_b;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0;
    m_run = 0; m_rel = 0; m_cand = 0;
    m_pulse = 1'b0; m_releasing = 1'b0;
    e_s = '0; e_a = '0; e_b = '0;
  endtask

  task automatic model_step(input logic [3:0] bt, input logic signed [W-1:0] a,
                            input logic signed [W-1:0] b);
    logic [3:0] sb;
    int code;
    sb = m_s2;
    code = -1;
    for (int i = 0; i < 4; i++) if (sb[i]) code = i;
    m_s2 = m_s1;
    m_s1 = bt;
    if (m_pulse) begin
      m_pulse = 1'b0;
      m_releasing = 1'b1;
      m_rel = 0;
    end else if (m_releasing) begin
      m_rel = (code >= 0) ? 0 : m_rel + 1;
      if (m_rel == DB) m_releasing = 1'b0;
    end else if (m_run == 0) begin
      if (code >= 0) begin
        m_run = 1;
        m_cand = code;
      end
    end else if (code == m_cand) begin
      m_run++;
      if (m_run == DB + 1) begin
        m_pulse = 1'b1;
        e_s = 2'(code);
        e_a = a;
        e_b = b;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
  endtask

  function automatic vec_t exp_vec();
    logic eb;
    eb = m_pulse || m_releasing || (m_run != 0);
    return {m_pulse, eb, e_s, e_a, e_b};
  endfunction

  function automatic vec_t dut_vec();
    return {bus.op_valid, bus.busy, bus.s_1, bus.s_0, bus.a_out, bus.b_out};
  endfunction

  task automatic tick();
    logic [3:0] bt;
    logic signed [W-1:0] a, b;
    bt = bus.btn; a = bus.a_in; b = bus.b_in;
    @(posedge clk);
    if (reset) model_reset();
    else model_step(bt, a, b);
    #1;
  endtask

  task automatic settle();
    bus.btn = '0;
    repeat (2 * DB + 8) tick();
  endtask

  task automatic test_reset();
    bus.btn = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL reset_pre cyc %0d: got %h want %h", k, dut_vec(), exp_vec());
      end
    end
    #3 reset = 1'b1;
    #1;
    checks++;
    if (dut_vec() !== '0) begin
      failures++;
      $display("FAIL reset_immediate: got %h want 0", dut_vec());
    end
    model_reset();
    #2 reset = 1'b0;
    settle();
  endtask

  task automatic test_single_press();
    int lat, pulses;
    lat = -1; pulses = 0;
    bus.a_in = 8'sd5; bus.b_in = 8'sd3; bus.btn = 4'b0100;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL single_press cyc %0d: got %h want %h", k, dut_vec(), exp_vec());
      end
      if (bus.op_valid) begin
        pulses++;
        if (lat < 0) lat = k;
      end
    end
    checks++;
    if (lat !== DB + 2) begin
      failures++;
      $display("FAIL single_latency: got %0d want %0d", lat, DB + 2);
    end
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("FAIL single_pulses: got %0d want 1", pulses);
    end
    checks++;
    if ({bus.s_1, bus.s_0, bus.a_out, bus.b_out} !== {2'b10, 8'sd5, 8'sd3}) begin
      failures++;
      $display("FAIL single_outputs: got s=%b%b a=%0d b=%0d want s=10 a=5 b=3",
               bus.s_1, bus.s_0, bus.a_out, bus.b_out);
    end
    bus.a_in = W'(-7);
    repeat (3) tick();
    checks++;
    if (bus.a_out !== 8'sd5) begin
      failures++;
      $display("FAIL single_hold_a: got %0d want 5", bus.a_out);
    end
  endtask

  task automatic test_bounce();
    int lat, pulses;
    lat = -1; pulses = 0;
    settle();
    for (int c = 0; c < 20; c++) begin
      bus.btn = ((c / 2) % 2 == 0) ? 4'b0010 : 4'b0000;
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL bounce cyc %0d: got %h want %h", c, dut_vec(), exp_vec());
      end
      if (bus.op_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL bounce_no_pulse: got %0d want 0", pulses);
    end
    bus.btn = 4'b0010;
    for (int k = 0; k < 15; k++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL bounce_hold cyc %0d: got %h want %h", k, dut_vec(), exp_vec());
      end
      if (bus.op_valid) begin
        pulses++;
        if (lat < 0) lat = k;
      end
    end
    checks++;
    if (pulses !== 1 || lat !== DB + 2) begin
      failures++;
      $display("FAIL bounce_pulse: got pulses=%0d lat=%0d want 1 and %0d", pulses, lat, DB + 2);
    end
    checks++;
    if ({bus.s_1, bus.s_0} !== 2'b01) begin
      failures++;
      $display("FAIL bounce_code: got %b%b want 01", bus.s_1, bus.s_0);
    end
  endtask

  task automatic test_priority();
    int pulses;
    pulses = 0;
    settle();
    bus.a_in = W'(-128); bus.b_in = 8'sd127; bus.btn = 4'b1001;
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL priority cyc %0d: got %h want %h", k, dut_vec(), exp_vec());
      end
      if (bus.op_valid) pulses++;
    end
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("FAIL priority_pulses: got %0d want 1", pulses);
    end
    checks++;
    if ({bus.s_1, bus.s_0, bus.a_out, bus.b_out} !== {2'b11, 8'h80, 8'h7f}) begin
      failures++;
      $display("FAIL priority_outputs: got s=%b%b a=%0d b=%0d want s=11 a=-128 b=127",
               bus.s_1, bus.s_0, bus.a_out, bus.b_out);
    end
  endtask

  task automatic test_hold_repress();
    int pulses, lat;
    logic [3:0] rel_pat [$];
    pulses = 0; lat = -1;
    settle();
    bus.a_in = 8'sd17; bus.b_in = W'(-3); bus.btn = 4'b0001;
    for (int k = 0; k < 100; k++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL hold cyc %0d: got %h want %h", k, dut_vec(), exp_vec());
      end
      if (bus.op_valid) pulses++;
      if (k >= 2) begin
        checks++;
        if (bus.busy !== 1'b1) begin
          failures++;
          $display("FAIL hold_busy cyc %0d: got %b want 1", k, bus.busy);
        end
      end
    end
    checks++;
    if (pulses !== 1 || {bus.s_1, bus.s_0} !== 2'b00 || bus.a_out !== 8'sd17) begin
      failures++;
      $display("FAIL hold_result: got pulses=%0d s=%b%b a=%0d want 1 00 17",
               pulses, bus.s_1, bus.s_0, bus.a_out);
    end
    rel_pat = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001};
    for (int i = 0; i < DB + 4; i++) rel_pat.push_back(4'b0000);
    pulses = 0;
    foreach (rel_pat[i]) begin
      bus.btn = rel_pat[i];
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL release cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      if (bus.op_valid) pulses++;
    end
    checks++;
    if (pulses !== 0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL release_done: got pulses=%0d busy=%b want 0 0", pulses, bus.busy);
    end
    bus.a_in = W'(-50); bus.b_in = 8'sd60; bus.btn = 4'b0100;
    for (int k = 0; k < 15; k++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL repress cyc %0d: got %h want %h", k, dut_vec(), exp_vec());
      end
      if (bus.op_valid) begin
        pulses++;
        if (lat < 0) lat = k;
      end
    end
    checks++;
    if (pulses !== 1 || lat !== DB + 2 || {bus.s_1, bus.s_0} !== 2'b10) begin
      failures++;
      $display("FAIL repress_result: got pulses=%0d lat=%0d s=%b%b want 1 %0d 10",
               pulses, lat, bus.s_1, bus.s_0, DB + 2);
    end
  endtask

  task automatic test_reset_debounce();
    int lat, pulses;
    lat = -1; pulses = 0;
    settle();
    bus.a_in = 8'sd9; bus.b_in = W'(-9); bus.btn = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL rst_deb_pre cyc %0d: got %h want %h", k, dut_vec(), exp_vec());
      end
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (dut_vec() !== '0) begin
      failures++;
      $display("FAIL rst_deb_immediate: got %h want 0", dut_vec());
    end
    tick();
    checks++;
    if (dut_vec() !== '0) begin
      failures++;
      $display("FAIL rst_deb_held: got %h want 0", dut_vec());
    end
    reset = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL rst_deb_after cyc %0d: got %h want %h", k, dut_vec(), exp_vec());
      end
      if (bus.op_valid) begin
        pulses++;
        if (lat < 0) lat = k;
      end
    end
    checks++;
    if (pulses !== 1 || lat !== DB + 2 || {bus.s_1, bus.s_0} !== 2'b11 || bus.a_out !== 8'sd9) begin
      failures++;
      $display("FAIL rst_deb_result: got pulses=%0d lat=%0d s=%b%b a=%0d want 1 %0d 11 9",
               pulses, lat, bus.s_1, bus.s_0, bus.a_out, DB + 2);
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    settle();
    for (int k = 0; k < 800; k++) begin
      if (hold == 0) begin
        bus.btn = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
        hold = $urandom_range(1, 12);
      end
      hold--;
      bus.a_in = W'($urandom);
      bus.b_in = W'($urandom);
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc %0d: got %h want %h", k, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.btn = '0; bus.a_in = '0; bus.b_in = '0;
    model_reset();
    #12 reset = 1'b0;
    test_reset();
    test_single_press();
    test_bounce();
    test_priority();
    test_hold_repress();
    test_reset_debounce();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/op_select_encoder.md
Name: op_select_encoder

Overview:
- Front end for the arithmetic `decoder`. Turns four raw push-buttons into a registered 2-bit operation select (`s_1`, `s_0`).
- Captures the signed 8-bit operands `a_in`/`b_in` at the moment a command is accepted.
- Synchronises and debounces the buttons, priority-encodes them and issues exactly one command per press, with a one-cycle valid pulse.
- Sits between the board switches/buttons in `top` and the `decoder`, whose R output feeds the seven-segment path.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles needed to accept a press or a release. Must be ≥1; the board build overrides it.
- W, 8, operand width in bits.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- btn  in  4  raw buttons b1..b4 mapped to btn[0]..btn[3], active-high, asynchronous
- a_in  in  W  signed operand A from switches
- b_in  in  W  signed operand B from switches
- s_1  out  1  registered opcode bit 1 to decoder
- s_0  out  1  registered opcode bit 0 to decoder
- a_out  out  W  signed operand A latched at issue
- b_out  out  W  signed operand B latched at issue
- op_valid  out  1  one-cycle pulse: new command issued
- busy  out  1  high whenever state ≠ IDLE

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, counter = 0, synchroniser flops = 0.
  - s_1 = s_0 = 0, a_out = b_out = 0, op_valid = 0, busy = 0.
- Synchronisation: btn passes through a 2-flop synchroniser to give sbtn[3:0]. The FSM never looks at raw btn.
- Priority encode of sbtn, highest index wins:
  - btn[3] → 11, btn[2] → 10, btn[1] → 01, btn[0] → 00.
  - `any` = |sbtn.
- State IDLE:
  - If `any`: latch cand = code, cnt ← 0, go to DEBOUNCE.
- State DEBOUNCE:
  - If !any or code ≠ cand: go to IDLE with no output change.
  - Else if cnt == DEBOUNCE_CYCLES−1: go to ISSUE.
  - Else cnt++.
- Transition into ISSUE, on the same edge:
  - {s_1, s_0} ← cand.
  - a_out ← a_in, b_out ← b_in (signed; no extension or truncation).
- State ISSUE:
  - op_valid = 1. It is a registered or Moore output, high for exactly one cycle.
  - Next state is WAIT_RELEASE with cnt ← 0.
- State WAIT_RELEASE:
  - Any sbtn ≠ 0 resets cnt to 0.
  - sbtn == 0 with cnt == DEBOUNCE_CYCLES−1 → IDLE.
  - Otherwise sbtn == 0 → cnt++.
  - No new command can issue until the release is debounced.
- Latency: with btn held stable from before edge 0, op_valid is high from edge DEBOUNCE_CYCLES+2 to edge DEBOUNCE_CYCLES+3. For the default that is edges 6 to 7.
- Outputs hold between commands:
  - s_1, s_0, a_out and b_out change only on entry to ISSUE.
  - Changes on a_in/b_in at any other time are ignored.
- Simultaneous buttons are resolved by priority. A change of the winning code during DEBOUNCE restarts debounce from IDLE.
- Reset mid-operation:
  - Aborts any state; no op_valid is produced.
  - A button still held after reset deasserts is treated as a fresh press and issues again after full debounce.
- Counter width is $clog2(DEBOUNCE_CYCLES)+1. The counter saturates and never wraps.

Decomposition:
- Package op_pkg:
  - typedef enum logic [1:0] opcode_t {OP_00, OP_01, OP_10, OP_11}.
  - typedef enum logic [1:0] state_t {IDLE, DEBOUNCE, ISSUE, WAIT_RELEASE}.
  - localparam OPW = 8.
- One sub-module: btn_sync, a 4-bit two-flop synchroniser with async reset.
- The priority encoder and FSM stay inline.

Test Plan:
- Reset: assert reset mid-cycle while btn = 4'b0100 → all outputs 0 immediately, before the next clk edge; busy = 0.
- Single press: a_in = 5, b_in = 3, btn = 4'b0100 held from edge 0, DEBOUNCE_CYCLES = 4 → op_valid high only between edges 6 and 7; s_1 = 1, s_0 = 0, a_out = 5, b_out = 3. Then change a_in = −7 → a_out stays 5.
- Bounce: btn[1] toggles every 2 cycles for 20 cycles, then is held → no op_valid during bouncing; exactly one pulse, DEBOUNCE_CYCLES+2 edges after the last toggle; {s_1, s_0} = 01.
- Priority: btn = 4'b1001 with a_in = −128, b_in = 127 → {s_1, s_0} = 11, a_out = −128, b_out = 127, one pulse.
- Hold and re-press: btn[0] held 100 cycles → exactly one pulse, busy high throughout. Release with a 3-cycle glitch, then press btn[2] → second pulse only after a clean release debounce plus press debounce; {s_1, s_0} = 10.
- Reset during DEBOUNCE: btn[3] held, pulse reset at edge 3 → no op_valid; outputs remain 0. After reset, the held btn[3] issues with {s_1, s_0} = 11 at DEBOUNCE_CYCLES+2 edges after reset release.
